// File: rtl/pulse_pkg.sv
// Shared constants for the pulse stretcher: FSM state encoding and default counter width.
package pulse_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/length/status bundle between a trigger source (master) and the stretcher (slave).
interface pulse_stretcher_if
  import pulse_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);
  logic             in;
  logic [LEN_W-1:0] len;
  logic             clr_overrun;
  logic             out;
  logic             done;
  logic             overrun;

  modport master (output in, len, clr_overrun, input out, done, overrun);
  modport slave  (input in, len, clr_overrun, output out, done, overrun);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a registered level of len cycles, with optional
// retrigger, post-pulse holdoff and a sticky overrun flag for rejected triggers.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int RETRIGGER = 1,
  parameter int HOLDOFF   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  pulse_stretcher_if.slave bus
);

  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] HOLD_CNT = LEN_W'(HOLDOFF);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             reject;
  logic [LEN_W-1:0] len_eff;

  // len=0 still yields a one-cycle pulse
  assign len_eff = (bus.len == '0) ? ONE : bus.len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // One counter serves both phases: remaining high cycles in ACTIVE, dead cycles in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_d = ACTIVE;
          cnt_d   = len_eff;
          out_d   = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.in && (RETRIGGER != 0)) begin
          cnt_d = len_eff;
        end else begin
          reject = bus.in;
          if (cnt_q <= ONE) begin
            out_d  = 1'b0;
            done_d = 1'b1;
            if (HOLDOFF > 0) begin
              state_d = GAP;
              cnt_d   = HOLD_CNT;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      GAP: begin
        reject = bus.in;
        if (cnt_q <= ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
    // a rejection on the same edge as a clear leaves the flag set
    if (reject)               ovr_d = 1'b1;
    else if (bus.clr_overrun) ovr_d = 1'b0;
    else                      ovr_d = ovr_q;
  end

  assign bus.out     = out_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: dut_a retriggerable/no holdoff, dut_b non-retriggerable/holdoff 2.
module tb_pulse_stretcher;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [511:0] o_tr, d_tr, v_tr;

  always #10 clock = ~clock;

  pulse_stretcher_if #(.LEN_W(8)) ia ();
  pulse_stretcher_if #(.LEN_W(8)) ib ();

  pulse_stretcher #(.LEN_W(8), .RETRIGGER(1), .HOLDOFF(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ia)
  );
  pulse_stretcher #(.LEN_W(8), .RETRIGGER(0), .HOLDOFF(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ib)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int sel, input logic i, input logic [7:0] l, input logic c);
    if (sel == 0) begin
      ia.in = i; ia.len = l; ia.clr_overrun = c;
    end else begin
      ib.in = i; ib.len = l; ib.clr_overrun = c;
    end
  endtask

  // bit m of each trace = output observed just after edge m of the sequence
  task automatic run(input int sel, input logic [63:0] trig, input logic [63:0] clr,
                     input logic [7:0] l0, input logic [7:0] lr, input int ncyc);
    o_tr = '0; d_tr = '0; v_tr = '0;
    for (int m = 0; m < ncyc; m++) begin
      set_in(sel, (m < 64) ? trig[m[5:0]] : 1'b0, (m == 0) ? l0 : lr,
             (m < 64) ? clr[m[5:0]] : 1'b0);
      cyc();
      if (sel == 0) begin
        o_tr[m] = ia.out; d_tr[m] = ia.done; v_tr[m] = ia.overrun;
      end else begin
        o_tr[m] = ib.out; d_tr[m] = ib.done; v_tr[m] = ib.overrun;
      end
    end
    set_in(sel, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 8'd0, 1'b0);
    set_in(1, 1'b0, 8'd0, 1'b0);
    reset_n = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if ({ia.out, ia.done, ia.overrun, ib.out, ib.done, ib.overrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 000000",
               {ia.out, ia.done, ia.overrun, ib.out, ib.done, ib.overrun});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    run(0, 64'h1, 64'h0, 8'd3, 8'd3, 8);
    n_chk++;
    if (o_tr[7:0] !== 8'h07) begin
      n_fail++; $display("FAIL %s_out: got %h expected 07", tag, o_tr[7:0]);
    end
    n_chk++;
    if (d_tr[7:0] !== 8'h08) begin
      n_fail++; $display("FAIL %s_done: got %h expected 08", tag, d_tr[7:0]);
    end
    n_chk++;
    if (v_tr[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL %s_overrun: got %h expected 00", tag, v_tr[7:0]);
    end
  endtask

  task automatic test_retrigger();
    run(0, 64'h5, 64'h0, 8'd4, 8'd4, 10);
    n_chk++;
    if (o_tr[9:0] !== 10'h03F) begin
      n_fail++; $display("FAIL retrig_out: got %h expected 03f", o_tr[9:0]);
    end
    n_chk++;
    if (d_tr[9:0] !== 10'h040) begin
      n_fail++; $display("FAIL retrig_done: got %h expected 040", d_tr[9:0]);
    end
  endtask

  task automatic test_reject();
    run(1, 64'h51, 64'h0, 8'd4, 8'd4, 10);
    n_chk++;
    if (o_tr[9:0] !== 10'h00F) begin
      n_fail++; $display("FAIL reject_out: got %h expected 00f", o_tr[9:0]);
    end
    n_chk++;
    if (d_tr[9:0] !== 10'h010) begin
      n_fail++; $display("FAIL reject_done: got %h expected 010", d_tr[9:0]);
    end
    n_chk++;
    if (v_tr[9:0] !== 10'h3F0) begin
      n_fail++; $display("FAIL reject_overrun: got %h expected 3f0", v_tr[9:0]);
    end
    set_in(1, 1'b0, 8'd0, 1'b1);
    cyc();
    set_in(1, 1'b0, 8'd0, 1'b0);
    n_chk++;
    if (ib.overrun !== 1'b0) begin
      n_fail++; $display("FAIL reject_clear: got %b expected 0", ib.overrun);
    end
  endtask

  task automatic test_gap_boundary();
    // trigger on the first edge after the gap is accepted
    run(1, 64'h11, 64'h0, 8'd1, 8'd1, 8);
    n_chk++;
    if (o_tr[7:0] !== 8'h11) begin
      n_fail++; $display("FAIL gap_after_out: got %h expected 11", o_tr[7:0]);
    end
    n_chk++;
    if (d_tr[7:0] !== 8'h22) begin
      n_fail++; $display("FAIL gap_after_done: got %h expected 22", d_tr[7:0]);
    end
    n_chk++;
    if (v_tr[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL gap_after_overrun: got %h expected 00", v_tr[7:0]);
    end
  endtask

  task automatic test_set_wins();
    // clr_overrun held high; trigger on the last gap edge must still set the flag
    run(1, 64'h9, 64'hFF, 8'd1, 8'd1, 8);
    n_chk++;
    if (o_tr[7:0] !== 8'h01) begin
      n_fail++; $display("FAIL setwins_out: got %h expected 01", o_tr[7:0]);
    end
    n_chk++;
    if (d_tr[7:0] !== 8'h02) begin
      n_fail++; $display("FAIL setwins_done: got %h expected 02", d_tr[7:0]);
    end
    n_chk++;
    if (v_tr[7:0] !== 8'h08) begin
      n_fail++; $display("FAIL setwins_overrun: got %h expected 08", v_tr[7:0]);
    end
  endtask

  task automatic test_len_zero();
    run(0, 64'h1, 64'h0, 8'd0, 8'd0, 4);
    n_chk++;
    if (o_tr[3:0] !== 4'h1) begin
      n_fail++; $display("FAIL len0_out: got %h expected 1", o_tr[3:0]);
    end
    n_chk++;
    if (d_tr[3:0] !== 4'h2) begin
      n_fail++; $display("FAIL len0_done: got %h expected 2", d_tr[3:0]);
    end
  endtask

  task automatic test_len_max();
    logic [259:0] eo;
    logic [259:0] ed;
    eo = '0;
    ed = '0;
    for (int i = 0; i < 255; i++) eo[i] = 1'b1;
    ed[255] = 1'b1;
    run(0, 64'h1, 64'h0, 8'd255, 8'd255, 260);
    n_chk++;
    if (o_tr[259:0] !== eo) begin
      n_fail++; $display("FAIL len255_out: got %h expected %h", o_tr[259:0], eo);
    end
    n_chk++;
    if (d_tr[259:0] !== ed) begin
      n_fail++; $display("FAIL len255_done: got %h expected %h", d_tr[259:0], ed);
    end
  endtask

  task automatic test_held();
    run(0, 64'h1F, 64'h0, 8'd2, 8'd2, 10);
    n_chk++;
    if (o_tr[9:0] !== 10'h03F) begin
      n_fail++; $display("FAIL held_out: got %h expected 03f", o_tr[9:0]);
    end
    n_chk++;
    if (d_tr[9:0] !== 10'h040) begin
      n_fail++; $display("FAIL held_done: got %h expected 040", d_tr[9:0]);
    end
  endtask

  task automatic test_len_change();
    run(0, 64'h1, 64'h0, 8'd3, 8'd200, 8);
    n_chk++;
    if (o_tr[7:0] !== 8'h07) begin
      n_fail++; $display("FAIL lenchg_out: got %h expected 07", o_tr[7:0]);
    end
    n_chk++;
    if (d_tr[7:0] !== 8'h08) begin
      n_fail++; $display("FAIL lenchg_done: got %h expected 08", d_tr[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    run(0, 64'h1, 64'h0, 8'd10, 8'd10, 3);
    n_chk++;
    if (ia.out !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_out: got %b expected 1", ia.out);
    end
    #3 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ia.out, ia.done, ia.overrun} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_async: got %b expected 000", {ia.out, ia.done, ia.overrun});
    end
    cyc();
    cyc();
    n_chk++;
    if ({ia.out, ia.done} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_held: got %b expected 00", {ia.out, ia.done});
    end
    reset_n = 1'b1;
    test_basic("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_retrigger();
    test_reject();
    test_gap_boundary();
    test_set_wins();
    test_len_zero();
    test_len_max();
    test_held();
    test_len_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter LEN_W, default 8: width of the length input and internal counter.
REQ-002 Parameter RETRIGGER, default 1: 1 = a trigger while active reloads the count; 0 = a trigger while active is ignored.
REQ-003 Parameter HOLDOFF, default 0: number of dead cycles after out falls during which triggers are ignored.
REQ-004 The block SHALL have: clock  input  1  system clock, rising edge active.
REQ-005 The block SHALL have: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have: in  input  1  trigger, nominally a one-cycle pulse, sampled on every rising clock edge.
REQ-007 The block SHALL have: len  input  LEN_W  stretch length in cycles, sampled only on an accepted trigger.
REQ-008 The block SHALL have: clr_overrun  input  1  synchronous clear of overrun.
REQ-009 The block SHALL have: out  output  1  stretched level.
REQ-010 The block SHALL have: done  output  1  one-cycle pulse marking the end of a stretch.
REQ-011 The block SHALL have: overrun  output  1  sticky flag for a rejected trigger.

Function
REQ-012 State machine SHALL have three states: IDLE, ACTIVE, GAP.
REQ-013 IDLE: in=1 at edge k SHALL be accepted; out=1 in cycles k+1 .. k+L; state becomes ACTIVE. L = len sampled at edge k, with len=0 treated as L=1.
REQ-014 out SHALL be a registered output with zero combinational path from in.
REQ-015 At the end of a stretch, state SHALL go to GAP if HOLDOFF>0, else to IDLE; done=1 for exactly cycle k+L+1.
REQ-016 GAP SHALL last exactly HOLDOFF cycles with out=0, then return to IDLE.
REQ-017 A trigger seen during GAP SHALL be ignored and SHALL set overrun.
REQ-018 RETRIGGER=1: in=1 at edge j while ACTIVE (including the final active cycle) SHALL reload the count, so out stays high through cycle j+len(j), with no low gap and no done at the original end.
REQ-019 RETRIGGER=0: in=1 while ACTIVE (including the final active cycle) SHALL be ignored, SHALL set overrun, and SHALL NOT change timing.
REQ-020 in held high for N cycles SHALL count as N consecutive triggers.
REQ-021 overrun SHALL stay high until clr_overrun=1 or reset.
REQ-022 clr_overrun and a new rejected trigger on the same edge: overrun SHALL end up 1 (set wins).
REQ-023 Counter arithmetic SHALL be LEN_W bits and SHALL never wrap: maximum stretch = 2^LEN_W-1 cycles.
REQ-024 Changes on len while ACTIVE SHALL NOT affect the current stretch unless a trigger is accepted.

Reset
REQ-025 reset_n=0 SHALL immediately force state=IDLE, counter=0, out=0, done=0, overrun=0.
REQ-026 Reset asserted mid-stretch or mid-GAP SHALL abort the operation without issuing done.
REQ-027 The first trigger SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-028 The state encoding (IDLE/ACTIVE/GAP) SHALL be defined as constants in the shared package pulse_pkg, which also holds the default LEN_W.
REQ-029 The design SHALL be a single module with no sub-modules.
REQ-030 The down-counter SHALL be shared between the ACTIVE and GAP phases.

Verification (20 ns clock period, LEN_W=8)
REQ-031 Basic stretch, RETRIGGER=1, HOLDOFF=0: len=3, one-cycle in at edge k -> out high for cycles k+1..k+3, done=1 at k+4, overrun stays 0.
REQ-032 Retrigger, RETRIGGER=1: len=4, triggers at k and k+2 -> out continuously high k+1..k+6, single done at k+7.
REQ-033 Reject, RETRIGGER=0, HOLDOFF=2: len=4, triggers at k, k+4, and k+6 (k+6 falls in GAP) -> out high k+1..k+4 only, done at k+5, overrun=1; then clr_overrun -> overrun=0.
REQ-034 Boundary: len=0 -> out high for exactly 1 cycle. len=255 -> out high for exactly 255 cycles with no wrap.
REQ-035 Held input, RETRIGGER=1: in held high 5 cycles with len=2 -> out high continuously until 2 cycles after in falls, one done.
REQ-036 Reset mid-operation: reset_n pulled low mid-stretch -> out=0 immediately, no done. After release, a new trigger behaves exactly as in REQ-031.
